ula_issue_ctrl: RTL and testbench
=================================

Name: ula_issue_ctrl

Overview:
Initiator side of the ULA interface. It accepts ALU commands over a valid/ready handshake and reads source operands from an internal register file. It drives A/B/ULAOp into an external combinational ULA, then captures the ULA's result and zero outputs and writes them back. It sits between the NanoRisc decode stage and the ULA.

Parameters:
DATA_W, 8, operand/result width; must match the ULA
NUM_REGS, 4, register-file depth
ADDR_W, 2, register address width; must equal clog2(NUM_REGS)

Ports:
clock  input  1  single system clock; all state updates on the rising edge
reset_n  input  1  asynchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command
cmd_op  input  2  0=add, 1=sub (A-B), 2=mul, 3=illegal
cmd_rd  input  ADDR_W  destination register
cmd_ra  input  ADDR_W  source register for A
cmd_rb  input  ADDR_W  source register for B
load_en  input  1  direct register write strobe
load_addr  input  ADDR_W  direct write address
load_data  input  DATA_W  direct write data
ula_a  output  DATA_W  registered A operand to the ULA
ula_b  output  DATA_W  registered B operand to the ULA
ula_op  output  2  registered ULAOp to the ULA
ula_result  input  DATA_W  ULA result (combinational from ula_a/ula_b/ula_op)
ula_zero  input  1  ULA zero flag
done  output  1  one-cycle pulse when a result is written back
result  output  DATA_W  last written-back result
zero_flag  output  1  ula_zero captured with the last result
err  output  1  one-cycle pulse on an illegal opcode

Behaviour:
- Clocking and reset
  - Single clock domain.
  - reset_n low asynchronously clears: state=IDLE, all registers, ula_a, ula_b, ula_op, result, zero_flag, done and err to 0.
  - A reset asserted mid-operation aborts the command; no write-back occurs.
- States: IDLE, EXEC, DONE.
- cmd_ready = (state==IDLE), combinational. It is 1 during and immediately after reset.
- IDLE, on cmd_valid && cmd_ready at an edge:
  - op!=3: latch ula_a=reg[ra], ula_b=reg[rb], ula_op=op, and rd internally; go to EXEC.
  - op==3: err=1 for the next cycle; stay in IDLE; ULA outputs and registers are unchanged.
- Operand sampling: operands are taken from the register values before the edge. A load_en to ra/rb on the accepting edge is not forwarded.
- EXEC (exactly 1 cycle), at the next edge:
  - reg[rd]=ula_result; result=ula_result; zero_flag=ula_zero; done=1.
  - Go to DONE.
- DONE: done deasserts at the next edge; go to IDLE.
- Latency and throughput:
  - Accept at edge N, write-back and done high at edge N+1, cmd_ready high again after edge N+2.
  - Maximum throughput is 1 command per 3 cycles.
- ula_a/ula_b/ula_op hold their values after the operation until the next accepted command.
- Arithmetic is performed entirely by the ULA. This block does no width extension and stores the low DATA_W bits as returned, so mul wraps modulo 2^DATA_W.
- load_en:
  - Accepted in any state; reg[load_addr]=load_data at the edge.
  - If it coincides with the EXEC write-back to the same register, the write-back wins.
- done and err are never high in the same cycle.
- rd may equal ra and/or rb. Operands are already latched, so this is safe.

Optional Feature:
- Macro ULA_DBG_READ_EN.
- Defined: adds ports dbg_addr (input, ADDR_W) and dbg_data (output, DATA_W).
  - dbg_data = reg[dbg_addr], combinational.
  - It reflects writes from the edge after they occur.
- Not defined: the ports do not exist; the register file is observable only through result.
- Core behaviour is identical either way.

Test Plan:
- Add: load R0=3, R1=7; cmd add rd=R2, ra=R0, rb=R1 -> ula_a=3, ula_b=7, ula_op=0 one cycle after accept; done pulse; result=10, zero_flag=0; cmd_ready low exactly 2 cycles.
- Sub/mul: R0=7, R1=3; sub rd=R2 -> result=4. Then mul rd=R3 -> result=21. With DATA_W=8, R0=R1=16 mul -> result=0, zero_flag=1.
- Zero: R0=5; sub rd=R1, ra=R0, rb=R0 -> result=0, zero_flag=1. A following add with result 2 -> zero_flag=0.
- Handshake: hold cmd_valid high with 2 commands back-to-back -> second accepted only when cmd_ready returns, 3 cycles after the first. op=3 -> err pulses 1 cycle, no done, registers unchanged, cmd_ready stays 1.
- Collision: load_en to R2=0x55 on the same edge as the write-back of 10 into R2 -> R2=10. load to ra on the accept edge -> operand uses the old value.
- Reset: assert reset_n=0 during EXEC -> outputs 0 immediately, no done, all registers 0, cmd_ready=1. With ULA_DBG_READ_EN defined, dbg_data reads back every register value above.

Source files
------------

// File: rtl/ula_issue_ctrl.sv
// ULA issue controller: accepts ALU commands, reads operands from a local register file,
// drives an external combinational ULA and writes the result back. Optional debug read port: ULA_DBG_READ_EN.
module ula_issue_ctrl #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic [ADDR_W-1:0] cmd_ra,
    input  logic [ADDR_W-1:0] cmd_rb,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] ula_a,
    output logic [DATA_W-1:0] ula_b,
    output logic [1:0]        ula_op,
    input  logic [DATA_W-1:0] ula_result,
    input  logic              ula_zero,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              zero_flag,
`ifdef ULA_DBG_READ_EN
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
`endif
    output logic              err
);

    // state | meaning
    // IDLE  | ready for a command; illegal opcode pulses err
    // EXEC  | operands on the ULA, capture result at next edge
    // DONE  | done pulse cycle, back to IDLE at next edge
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [ADDR_W-1:0] rd_q;

    assign cmd_ready = (state == IDLE);

`ifdef ULA_DBG_READ_EN
    assign dbg_data = regs[dbg_addr];
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            rd_q      <= '0;
            ula_a     <= '0;
            ula_b     <= '0;
            ula_op    <= '0;
            result    <= '0;
            zero_flag <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (load_en) begin
                regs[load_addr] <= load_data;
            end
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_op == 2'd3) begin
                            err <= 1'b1;
                        end else begin
                            ula_a  <= regs[cmd_ra];
                            ula_b  <= regs[cmd_rb];
                            ula_op <= cmd_op;
                            rd_q   <= cmd_rd;
                            state  <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    // placed after the load so a same-edge write-back to the same register wins
                    regs[rd_q] <= ula_result;
                    result     <= ula_result;
                    zero_flag  <= ula_zero;
                    done       <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ula_issue_ctrl.sv
// Bench for ula_issue_ctrl: directed test-plan sequences plus random traffic
// against a transaction-level reference model; includes a behavioural ULA.
module tb_ula_issue_ctrl;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op, cmd_rd, cmd_ra, cmd_rb;
    logic       load_en;
    logic [1:0] load_addr;
    logic [7:0] load_data;
    logic [7:0] ula_a, ula_b, ula_result, result;
    logic [1:0] ula_op;
    logic       ula_zero, done, zero_flag, err;
`ifdef ULA_DBG_READ_EN
    logic [1:0] dbg_addr = 2'd0;
    logic [7:0] dbg_data;
`endif

    int total = 0;
    int bad   = 0;

    always #10 clock = ~clock;

    // external ULA
    always_comb begin
        case (ula_op)
            2'd0:    ula_result = ula_a + ula_b;
            2'd1:    ula_result = ula_a - ula_b;
            2'd2:    ula_result = ula_a * ula_b;
            default: ula_result = 8'd0;
        endcase
    end
    assign ula_zero = (ula_result == 8'd0);

    ula_issue_ctrl #(.DATA_W(8), .NUM_REGS(4), .ADDR_W(2)) dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .ula_a(ula_a), .ula_b(ula_b), .ula_op(ula_op),
        .ula_result(ula_result), .ula_zero(ula_zero),
        .done(done), .result(result), .zero_flag(zero_flag),
`ifdef ULA_DBG_READ_EN
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
`endif
        .err(err)
    );

    // reference model state
    int m_regs [4];
    int e_a, e_b, e_op, e_res;
    int e_zero, e_done, e_err;
    int busy;         // cycles left before the next command can be taken
    int p_rd;

    task automatic chk(input string tag, input int got, input int expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, expv, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 0;
        e_a = 0; e_b = 0; e_op = 0; e_res = 0;
        e_zero = 0; e_done = 0; e_err = 0; busy = 0; p_rd = 0;
    endtask

    function automatic int arith(input int a, input int b, input int op);
        int r;
        case (op)
            0:       r = a + b;
            1:       r = a - b + 256;
            default: r = a * b;
        endcase
        return r % 256;
    endfunction

    task automatic step(input logic v, input logic [1:0] op, input logic [1:0] rd,
                        input logic [1:0] ra, input logic [1:0] rb,
                        input logic le, input logic [1:0] la, input logic [7:0] ld);
        int nregs [4];
        int nbusy;
        @(negedge clock);
        cmd_valid = v; cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb;
        load_en = le; load_addr = la; load_data = ld;
        #1;
        chk("cmd_ready", int'(cmd_ready), int'(busy == 0));

        nregs  = m_regs;
        e_done = 0;
        e_err  = 0;
        nbusy  = (busy > 0) ? busy - 1 : 0;
        if (le) nregs[la] = ld;
        if (busy == 2) begin
            e_res  = arith(e_a, e_b, e_op);
            e_zero = int'(e_res == 0);
            e_done = 1;
            nregs[p_rd] = e_res;
        end
        if (busy == 0 && v) begin
            if (op == 2'd3) begin
                e_err = 1;
            end else begin
                e_a  = m_regs[ra];
                e_b  = m_regs[rb];
                e_op = op;
                p_rd = rd;
                nbusy = 2;
            end
        end
        busy   = nbusy;
        m_regs = nregs;

        @(posedge clock);
        #1;
        chk("ula_a", int'(ula_a), e_a);
        chk("ula_b", int'(ula_b), e_b);
        chk("ula_op", int'(ula_op), e_op);
        chk("done", int'(done), e_done);
        chk("err", int'(err), e_err);
        chk("result", int'(result), e_res);
        chk("zero_flag", int'(zero_flag), e_zero);
`ifdef ULA_DBG_READ_EN
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            chk("dbg_data", int'(dbg_data), m_regs[i]);
        end
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 8'd0);
    endtask

    task automatic load(input logic [1:0] a, input logic [7:0] d);
        step(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, a, d);
    endtask

    task automatic cmd(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] ra, input logic [1:0] rb);
        step(1'b1, op, rd, ra, rb, 1'b0, 2'd0, 8'd0);
        step(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 8'd0);
        step(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 8'd0);
    endtask

    function automatic logic [7:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 8'd0;
            1: return 8'd1;
            2: return 8'd16;
            3: return 8'd255;
            4: return 8'd5;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        reset_n = 1'b0;
        cmd_valid = 1'b0; cmd_op = 2'd0; cmd_rd = 2'd0; cmd_ra = 2'd0; cmd_rb = 2'd0;
        load_en = 1'b0; load_addr = 2'd0; load_data = 8'd0;
        model_reset();
        #3;
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_done", int'(done), 0);
        chk("rst_result", int'(result), 0);
        @(negedge clock);
        reset_n = 1'b1;
        idle(1);

        // add 3+7
        load(2'd0, 8'd3);
        load(2'd1, 8'd7);
        step(1'b1, 2'd0, 2'd2, 2'd0, 2'd1, 1'b0, 2'd0, 8'd0);
        chk("add_a", int'(ula_a), 3);
        chk("add_b", int'(ula_b), 7);
        step(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 8'd0);
        chk("add_done", int'(done), 1);
        chk("add_res", int'(result), 10);
        chk("add_zero", int'(zero_flag), 0);
        idle(1);

        // sub, mul, mul wrap
        load(2'd0, 8'd7);
        load(2'd1, 8'd3);
        cmd(2'd1, 2'd2, 2'd0, 2'd1);
        chk("sub_res", int'(result), 4);
        cmd(2'd2, 2'd3, 2'd0, 2'd1);
        chk("mul_res", int'(result), 21);
        load(2'd0, 8'd16);
        load(2'd1, 8'd16);
        cmd(2'd2, 2'd3, 2'd0, 2'd1);
        chk("mul_wrap", int'(result), 0);
        chk("mul_wrap_z", int'(zero_flag), 1);

        // zero flag set then cleared
        load(2'd0, 8'd5);
        cmd(2'd1, 2'd1, 2'd0, 2'd0);
        chk("sub_zero", int'(zero_flag), 1);
        load(2'd2, 8'd1);
        cmd(2'd0, 2'd3, 2'd2, 2'd2);
        chk("add2_res", int'(result), 2);
        chk("add2_zero", int'(zero_flag), 0);

        // back-to-back with cmd_valid held, then illegal op
        for (int i = 0; i < 4; i++) step(1'b1, 2'd0, 2'd3, 2'd3, 2'd2, 1'b0, 2'd0, 8'd0);
        idle(2);
        step(1'b1, 2'd3, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 8'd0);
        chk("illegal_err", int'(err), 1);
        chk("illegal_ready", int'(cmd_ready), 1);
        idle(1);

        // write-back beats same-edge load; load on accept edge is not forwarded
        load(2'd0, 8'd3);
        load(2'd1, 8'd7);
        step(1'b1, 2'd0, 2'd2, 2'd0, 2'd1, 1'b0, 2'd0, 8'd0);
        step(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 2'd2, 8'h55);
        idle(1);
        step(1'b1, 2'd0, 2'd3, 2'd2, 2'd2, 1'b1, 2'd2, 8'd99);
        chk("fwd_a", int'(ula_a), 10);
        idle(2);
        chk("collide_res", int'(result), 20);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                 1'($urandom_range(0, 2) == 0), 2'($urandom), pick_val());
        end
        idle(3);

        // reset during EXEC
        load(2'd0, 8'd9);
        step(1'b1, 2'd0, 2'd1, 2'd0, 2'd0, 1'b0, 2'd0, 8'd0);
        @(negedge clock);
        cmd_valid = 1'b0; load_en = 1'b0;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_a", int'(ula_a), 0);
        chk("mid_rst_result", int'(result), 0);
        chk("mid_rst_ready", int'(cmd_ready), 1);
        @(posedge clock);
        #1;
        chk("mid_rst_done", int'(done), 0);
        @(negedge clock);
        reset_n = 1'b1;
        idle(1);
        load(2'd2, 8'd1);
        cmd(2'd0, 2'd3, 2'd0, 2'd1);
        chk("post_rst_res", int'(result), 0);
        chk("post_rst_zero", int'(zero_flag), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
